// File: rtl/q65_bus_pkg.sv
// Shared definitions for the q65 bus blocks: default bus geometry and
// the receiver capture state encoding.
package q65_bus_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NSRC  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/q65_bus_fifo.sv
// First-word fall-through FIFO with occupancy count; a push is accepted
// when not full, or when full with a pop in the same cycle.
module q65_bus_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             pop_s;
    logic             push_s;

    assign full      = (level_q == FULL_LVL);
    assign out_valid = (level_q != {LW{1'b0}});
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign level     = level_q;
    assign pop_s     = pop && out_valid;
    assign push_s    = push && (!full || pop_s);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        level_d = level_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            level_q <= level_d;
        end
    end

    // Storage array; contents are masked by out_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/q65_bus_receiver.sv
// Bus capture front end: on load, waits SETTLE cycles, samples the shared
// bus once, and queues the word only when exactly one driver was enabled.
module q65_bus_receiver
    import q65_bus_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NSRC   = DEF_NSRC,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       bus_data,
    input  logic [NSRC-1:0]        drv_en,
    input  logic                   load,
    output logic                   busy,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_contention,
    output logic                   err_float,
    output logic                   err_overflow,
    input  logic                   clear_err
);

    localparam int unsigned CW = $clog2(NSRC + 1);
    localparam logic [2:0] SETTLE_INIT = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

    function automatic logic [CW-1:0] popcount(input logic [NSRC-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    rx_state_e     state_q;
    logic [2:0]    cnt_q;
    logic          busy_q;
    logic          err_cont_q, err_cont_d;
    logic          err_float_q, err_float_d;
    logic          err_ovf_q, err_ovf_d;
    logic [CW-1:0] pc_s;
    logic          sample_s;
    logic          one_s;
    logic          pop_s;
    logic          fifo_full_s;

    assign sample_s = (state_q == ST_SAMPLE);
    assign pc_s     = popcount(drv_en);
    assign one_s    = (pc_s == CW'(1'b1));
    assign pop_s    = out_valid && out_ready;

    assign busy           = busy_q;
    assign err_contention = err_cont_q;
    assign err_float      = err_float_q;
    assign err_overflow   = err_ovf_q;

    // Capture sequencer: IDLE -> SETTLE (optional) -> one SAMPLE cycle -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        busy_q <= 1'b1;
                        if (SETTLE == 0) begin
                            state_q <= ST_SAMPLE;
                        end else begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= SETTLE_INIT;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_SAMPLE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a detection in the clearing cycle survives the clear.
    always_comb begin
        err_cont_d  = (clear_err ? 1'b0 : err_cont_q)
                    | (sample_s && (pc_s > CW'(1'b1)));
        err_float_d = (clear_err ? 1'b0 : err_float_q)
                    | (sample_s && (pc_s == {CW{1'b0}}));
        err_ovf_d   = (clear_err ? 1'b0 : err_ovf_q)
                    | (sample_s && one_s && fifo_full_s && !pop_s);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cont_q  <= 1'b0;
            err_float_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            err_cont_q  <= err_cont_d;
            err_float_q <= err_float_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    q65_bus_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sample_s && one_s),
        .push_data (bus_data),
        .pop       (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (fifo_full_s),
        .level     (level)
    );

endmodule

// File: tb/tb_q65_bus_receiver.sv
// Scoreboard bench for q65_bus_receiver: a cycle-level reference model
// predicts pushes, flags and occupancy; a negedge monitor compares.
module tb_q65_bus_receiver;

    localparam int WIDTH  = 8;
    localparam int NSRC   = 2;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic       clk = 1'b0;
    logic       rst, load, out_ready, clear_err, load0, ready0;
    logic [7:0] bus_data;
    logic [1:0] drv_en;

    logic       busy, out_valid, err_contention, err_float, err_overflow;
    logic [7:0] out_data;
    logic [2:0] level;

    logic       busy0, valid0, econt0, efloat0, eovf0;
    logic [7:0] data0;
    logic [2:0] level0;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_q[$];
    int  m_level = 0;
    bit  m_pend  = 1'b0;
    int  m_cyc   = 0;
    int  m_samp  = 0;
    bit  m_cont  = 1'b0;
    bit  m_float = 1'b0;
    bit  m_ovf   = 1'b0;
    bit  mon_en  = 1'b0;

    always #5 clk = ~clk;

    q65_bus_receiver #(.WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH), .SETTLE(SETTLE)) u_dut (
        .clk(clk), .rst(rst), .bus_data(bus_data), .drv_en(drv_en), .load(load),
        .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .err_contention(err_contention), .err_float(err_float),
        .err_overflow(err_overflow), .clear_err(clear_err)
    );

    q65_bus_receiver #(.WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus_data(bus_data), .drv_en(drv_en), .load(load0),
        .busy(busy0), .out_data(data0), .out_valid(valid0), .out_ready(ready0),
        .level(level0), .err_contention(econt0), .err_float(efloat0),
        .err_overflow(eovf0), .clear_err(clear_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic capture(input logic [1:0] d, input logic [7:0] v);
        drv_en   = d;
        bus_data = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        step(2);
    endtask

    // Reference model: a load accepted at cycle c is sampled at cycle c+SETTLE+1.
    always @(posedge clk) begin
        bit sampled, pop, push, dc, df, dov;
        int n;
        if (rst) begin
            sb_q.delete();
            m_level = 0;
            m_pend  = 1'b0;
            m_cont  = 1'b0;
            m_float = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            sampled = 1'b0; push = 1'b0; dc = 1'b0; df = 1'b0; dov = 1'b0;
            pop = (m_level > 0) && out_ready;
            if (m_pend && m_cyc == m_samp) begin
                sampled = 1'b1;
                m_pend  = 1'b0;
                n = $countones(drv_en);
                if (n == 1) begin
                    if (m_level < DEPTH || pop) begin
                        sb_q.push_back(bus_data);
                        push = 1'b1;
                    end else begin
                        dov = 1'b1;
                    end
                end else if (n == 0) begin
                    df = 1'b1;
                end else begin
                    dc = 1'b1;
                end
            end
            if (!m_pend && !sampled && load) begin
                m_pend = 1'b1;
                m_samp = m_cyc + SETTLE + 1;
            end
            m_level = m_level + int'(push) - int'(pop);
            m_cont  = dc  | (clear_err ? 1'b0 : m_cont);
            m_float = df  | (clear_err ? 1'b0 : m_float);
            m_ovf   = dov | (clear_err ? 1'b0 : m_ovf);
        end
        m_cyc++;
    end

    // Monitor: compare DUT state with the model and consume the scoreboard on pops.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(m_pend));
            chk("level", 32'(level), 32'(m_level));
            chk("out_valid", 32'(out_valid), 32'(m_level > 0));
            chk("err_contention", 32'(err_contention), 32'(m_cont));
            chk("err_float", 32'(err_float), 32'(m_float));
            chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("head_expected", 32'(0), 32'(1));
                end else begin
                    chk("head_data", 32'(out_data), 32'(sb_q[0]));
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                    end
                end
            end else begin
                chk("empty_data_zero", 32'(out_data), 32'(0));
            end
        end
    end

    initial begin
        rst = 1'b1; load = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
        load0 = 1'b0; ready0 = 1'b1; bus_data = 8'h00; drv_en = 2'b00;
        step(1);
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);

        capture(2'b01, 8'hA5);
        chk("basic_valid", 32'(out_valid), 32'(1));
        chk("basic_data", 32'(out_data), 32'(8'hA5));
        chk("basic_level", 32'(level), 32'(1));

        capture(2'b11, 8'h3C);
        chk("contention_flag", 32'(err_contention), 32'(1));
        chk("contention_level", 32'(level), 32'(1));
        capture(2'b00, 8'hC3);
        chk("float_flag", 32'(err_float), 32'(1));
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk("cleared_cont", 32'(err_contention), 32'(0));
        chk("cleared_float", 32'(err_float), 32'(0));

        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            capture(2'b01, 8'(8'h10 + i));
        end
        chk("full_level", 32'(level), 32'(4));
        capture(2'b01, 8'hEE);
        chk("overflow_flag", 32'(err_overflow), 32'(1));
        chk("overflow_head", 32'(out_data), 32'(8'h10));
        drv_en = 2'b01; bus_data = 8'h77; load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("full_push_pop_level", 32'(level), 32'(4));
        chk("full_push_pop_head", 32'(out_data), 32'(8'h11));
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;

        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            capture(2'b01, 8'(i));
        end
        step(3);
        out_ready = 1'b0;
        chk("drained_level", 32'(level), 32'(0));

        drv_en = 2'b01; bus_data = 8'h99; load = 1'b1;
        step(1);
        load = 1'b0; rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_level", 32'(level), 32'(0));
        step(3);
        chk("abort_no_push", 32'(level), 32'(0));
        bus_data = 8'h55; load = 1'b1;
        step(4);
        load = 1'b0;
        step(3);
        chk("busy_load_ignored", 32'(level), 32'(2));
        out_ready = 1'b1;
        step(3);
        out_ready = 1'b0;

        drv_en = 2'b10; bus_data = 8'h3C; load0 = 1'b1;
        step(1);
        load0 = 1'b0;
        chk("s0_busy", 32'(busy0), 32'(1));
        chk("s0_not_yet", 32'(valid0), 32'(0));
        step(1);
        chk("s0_valid", 32'(valid0), 32'(1));
        chk("s0_data", 32'(data0), 32'(8'h3C));

        repeat (800) begin
            rst       = ($urandom_range(0, 99) == 0);
            load      = ($urandom_range(0, 2) == 0);
            out_ready = 1'($urandom_range(0, 1));
            clear_err = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 7) begin
                drv_en = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            end else begin
                drv_en = 2'($urandom);
            end
            bus_data = 8'($urandom);
            step(1);
        end
        rst = 1'b0; load = 1'b0; clear_err = 1'b0; out_ready = 1'b1;
        step(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
